// File: rtl/column_sweep_ctrl_pkg.sv
// Shared types, widths and fixed-point helpers for the drum-mesh column sweep.
// All datapath values are signed 1.17.
package column_sweep_ctrl_pkg;

   localparam int DW = 18;
   localparam int AW = 9;
   localparam int CW = 10;

   localparam logic signed [DW-1:0] ONE_MINUS_LSB = 18'h1ffff;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_e;

   // 1.17 x 1.17 product, truncated back to 1.17 (wraps on overflow)
   function automatic logic signed [DW-1:0] signed_mult(
      input logic signed [DW-1:0] a,
      input logic signed [DW-1:0] b
   );
      logic signed [2*DW-1:0] p;
      p = a * b;
      return p[2*DW-2:DW-1];
   endfunction

endpackage

// File: rtl/column_node.sv
// One mesh node update: discrete wave equation with damping, column neighbours only.
// Left/right neighbours are outside this column and contribute nothing here.
module column_node
   import column_sweep_ctrl_pkg::*;
(
   input  logic signed [DW-1:0] rho,
   input  logic signed [DW-1:0] eta_term,
   input  logic signed [DW-1:0] g_tension,
   input  logic signed [DW-1:0] u_n,
   input  logic signed [DW-1:0] u_n_prev,
   input  logic signed [DW-1:0] u_n_up,
   input  logic signed [DW-1:0] u_n_down,
   output logic signed [DW-1:0] u_next
);

   logic signed [DW-1:0] damp;
   logic signed [DW-1:0] rho_eff;
   logic signed [DW-1:0] lap;
   logic signed [DW-1:0] sum;

   always_comb begin
      damp    = ONE_MINUS_LSB - eta_term;
      rho_eff = rho + signed_mult(g_tension, signed_mult(u_n, u_n));
      lap     = u_n_up + u_n_down - (u_n <<< 2);
      sum     = signed_mult(rho_eff, lap) + (u_n <<< 1)
              - signed_mult(u_n_prev, damp);
      u_next  = signed_mult(sum, damp);
   end

endmodule

// File: rtl/column_sweep_ctrl.sv
// Sweeps one column through a ping-pong M10K pair, one node per cycle,
// writing u_next over u_prev and swapping bank roles at the end of each step.
module column_sweep_ctrl
   import column_sweep_ctrl_pkg::*;
#(
   parameter int ROWS       = 30,
   parameter int CENTER_ROW = 15
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic signed [DW-1:0] rho,
   input  logic signed [DW-1:0] eta_term,
   output logic                 busy,
   output logic                 done,
   output logic signed [DW-1:0] center_out,
   output logic                 center_valid,
   output logic                 bank_sel,
   output logic [AW-1:0]        a_rdaddr,
   output logic [AW-1:0]        b_rdaddr,
   output logic                 a_rden,
   output logic                 b_rden,
   input  logic signed [DW-1:0] a_q,
   input  logic signed [DW-1:0] b_q,
   output logic [AW-1:0]        wraddr,
   output logic signed [DW-1:0] wrdata,
   output logic                 a_wren,
   output logic                 b_wren
);

   localparam logic [CW-1:0] LAST_RUN = CW'(ROWS);
   localparam logic [CW-1:0] LAST_DRN = CW'(ROWS + 2);
   localparam logic [CW-1:0] CTR_CYC  = CW'(CENTER_ROW + 3);

   state_e state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic bank_sel_q, bank_sel_d;
   logic signed [DW-1:0] mid_q, mid_d;
   logic signed [DW-1:0] dn_q, dn_d;
   logic signed [DW-1:0] hold_q, hold_d;
   logic signed [DW-1:0] center_q, center_d;

   logic signed [DW-1:0] cur_q, prev_q, up_tap, u_next;
   logic cur_rd, prev_rd, cur_ok, wr_act;
   logic [AW-1:0] cur_addr, prev_addr, row_addr;

   assign cur_q  = bank_sel_q ? b_q : a_q;
   assign prev_q = bank_sel_q ? a_q : b_q;

   // Cycle c of a step: cur row c read, prev row c-1 read, row c-3 written.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bank_sel_d = bank_sel_q;
      cur_rd     = 1'b0;
      cur_addr   = '0;
      prev_rd    = 1'b0;
      prev_addr  = '0;
      cur_ok     = 1'b0;
      wr_act     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               cnt_d   = CW'(1);
               cur_rd  = 1'b1;
            end
         end
         ST_RUN: begin
            cnt_d     = cnt_q + CW'(1);
            cur_rd    = cnt_q < LAST_RUN;
            cur_addr  = cur_rd ? AW'(cnt_q) : '0;
            prev_rd   = 1'b1;
            prev_addr = AW'(cnt_q - CW'(1));
            cur_ok    = cnt_q >= CW'(2);
            wr_act    = cnt_q >= CW'(3);
            if (cnt_q == LAST_RUN) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            cnt_d  = cnt_q + CW'(1);
            cur_ok = cnt_q != LAST_DRN;
            wr_act = 1'b1;
            if (cnt_q == LAST_DRN) state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d    = ST_IDLE;
            bank_sel_d = ~bank_sel_q;
         end
         default: state_d = ST_IDLE;
      endcase
      // Rows past the rim (and stale bus data) enter the window as zero.
      up_tap   = cur_ok ? cur_q : '0;
      row_addr = wr_act ? AW'(cnt_q - CW'(3)) : '0;
   end

   column_node u_node (
      .rho       (rho),
      .eta_term  (eta_term),
      .g_tension ('0),
      .u_n       (mid_q),
      .u_n_prev  (prev_q),
      .u_n_up    (up_tap),
      .u_n_down  (dn_q),
      .u_next    (u_next)
   );

   always_comb begin
      mid_d    = up_tap;
      dn_d     = mid_q;
      hold_d   = hold_q;
      center_d = center_q;
      if (wr_act && cnt_q == CTR_CYC) hold_d = u_next;
      if (state_q == ST_DRAIN && cnt_q == LAST_DRN) center_d = hold_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         bank_sel_q <= 1'b0;
         mid_q      <= '0;
         dn_q       <= '0;
         hold_q     <= '0;
         center_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bank_sel_q <= bank_sel_d;
         mid_q      <= mid_d;
         dn_q       <= dn_d;
         hold_q     <= hold_d;
         center_q   <= center_d;
      end
   end

   assign busy         = state_q != ST_IDLE;
   assign done         = state_q == ST_DONE;
   assign center_valid = done;
   assign center_out   = center_q;
   assign bank_sel     = bank_sel_q;

   assign a_rden   = bank_sel_q ? prev_rd : cur_rd;
   assign b_rden   = bank_sel_q ? cur_rd : prev_rd;
   assign a_rdaddr = bank_sel_q ? prev_addr : cur_addr;
   assign b_rdaddr = bank_sel_q ? cur_addr : prev_addr;

   assign a_wren = wr_act & bank_sel_q;
   assign b_wren = wr_act & ~bank_sel_q;
   assign wraddr = row_addr;
   assign wrdata = wr_act ? u_next : '0;

endmodule

// File: tb/tb_column_sweep_ctrl.sv
// Self-checking bench: bank models around the DUT, a whole-column reference
// step model, and a per-cycle compare of every output against the timing table.
module tb_column_sweep_ctrl;

   localparam int R = 6;
   localparam int C = 5;

   typedef logic [17:0] col_t [R];

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [17:0] rho = '0;
   logic [17:0] eta_term = '0;
   logic        busy, done, center_valid, bank_sel;
   logic [17:0] center_out, wrdata;
   logic [8:0]  a_rdaddr, b_rdaddr, wraddr;
   logic        a_rden, b_rden, a_wren, b_wren;
   logic [17:0] a_q, b_q;

   column_sweep_ctrl #(.ROWS(R), .CENTER_ROW(C)) dut (
      .clk(clk), .reset(reset), .start(start),
      .rho(rho), .eta_term(eta_term),
      .busy(busy), .done(done),
      .center_out(center_out), .center_valid(center_valid),
      .bank_sel(bank_sel),
      .a_rdaddr(a_rdaddr), .b_rdaddr(b_rdaddr),
      .a_rden(a_rden), .b_rden(b_rden),
      .a_q(a_q), .b_q(b_q),
      .wraddr(wraddr), .wrdata(wrdata),
      .a_wren(a_wren), .b_wren(b_wren)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic longint wrap18(longint v);
      longint m;
      m = v & 64'h3ffff;
      if (m >= 131072) m = m - 262144;
      return m;
   endfunction

   function automatic longint sx(logic [17:0] v);
      return longint'($signed(v));
   endfunction

   function automatic longint smul(longint a, longint b);
      return wrap18((a * b) >>> 17);
   endfunction

   task automatic chk_near(string nm, logic [17:0] act, logic [17:0] exp);
      longint d;
      d = sx(act) - sx(exp);
      n_vec++;
      if (d > 2 || d < -2) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h +-2", nm, act, exp);
      end
   endtask

   // ---------------- bank models ----------------
   logic [17:0] a_mem [512];
   logic [17:0] b_mem [512];
   logic [17:0] a_init [512];
   logic [17:0] b_init [512];
   logic [17:0] a_p, b_p;
   bit load = 1'b0;
   int a_wr_cnt = 0, b_wr_cnt = 0, bad_rd = 0, coll = 0;

   always @(posedge clk) begin
      a_p <= a_rden ? a_mem[a_rdaddr] : 18'($urandom);
      b_p <= b_rden ? b_mem[b_rdaddr] : 18'($urandom);
      a_q <= a_p;
      b_q <= b_p;
      if (load) begin
         a_mem <= a_init;
         b_mem <= b_init;
      end else begin
         if (a_wren) a_mem[wraddr] <= wrdata;
         if (b_wren) b_mem[wraddr] <= wrdata;
      end
      if (a_wren) a_wr_cnt <= a_wr_cnt + 1;
      if (b_wren) b_wr_cnt <= b_wr_cnt + 1;
      if ((a_rden && a_rdaddr >= 9'(R)) || (b_rden && b_rdaddr >= 9'(R)))
         bad_rd <= bad_rd + 1;
      if ((a_rden && a_wren && a_rdaddr == wraddr) ||
          (b_rden && b_wren && b_rdaddr == wraddr))
         coll <= coll + 1;
   end

   // ---------------- reference model ----------------
   function automatic col_t model_step(bit bk, logic [17:0] rh,
                                       logic [17:0] et);
      col_t nx;
      longint u, up, dn, pv, damp, lap, t;
      damp = wrap18(131071 - sx(et));
      for (int i = 0; i < R; i++) begin
         u  = sx(bk ? b_mem[i] : a_mem[i]);
         up = (i == R-1) ? 0 : sx(bk ? b_mem[i+1] : a_mem[i+1]);
         dn = (i == 0) ? 0 : sx(bk ? b_mem[i-1] : a_mem[i-1]);
         pv = sx(bk ? a_mem[i] : b_mem[i]);
         lap = wrap18(up + dn - 4 * u);
         t = wrap18(smul(sx(rh), lap) + 2 * u - smul(pv, damp));
         nx[i] = 18'(smul(t, damp));
      end
      return nx;
   endfunction

   bit          m_act = 1'b0;
   int          m_cyc = 0;
   bit          m_bank = 1'b0;
   logic [17:0] m_center = '0;
   col_t        exp_nx;
   int          n_done = 0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_act    <= 1'b0;
         m_cyc    <= 0;
         m_bank   <= 1'b0;
         m_center <= '0;
      end else if (!m_act) begin
         if (start) begin
            exp_nx <= model_step(m_bank, rho, eta_term);
            m_act  <= 1'b1;
            m_cyc  <= 1;
         end
      end else begin
         m_cyc <= m_cyc + 1;
         if (m_cyc == R+2) m_center <= exp_nx[C];
         if (m_cyc == R+3) begin
            m_act  <= 1'b0;
            m_bank <= ~m_bank;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      bit acc, crd, prd, wr, e_ard, e_brd;
      int c;
      logic [8:0] ca, pa;
      if (!reset) begin
         acc = !m_act && start;
         c   = m_act ? m_cyc : 0;
         crd = acc || (m_act && c <= R-1);
         ca  = 9'(c);
         prd = m_act && c >= 1 && c <= R;
         pa  = 9'(c - 1);
         wr  = m_act && c >= 3 && c <= R+2;
         e_ard = m_bank ? prd : crd;
         e_brd = m_bank ? crd : prd;
         if (done) n_done++;
         chk("busy", busy, m_act);
         chk("done", done, m_act && c == R+3);
         chk("center_valid", center_valid, m_act && c == R+3);
         chk("bank_sel", bank_sel, m_bank);
         chk("center_out", center_out, m_center);
         chk("a_rden", a_rden, e_ard);
         chk("b_rden", b_rden, e_brd);
         if (e_ard) chk("a_rdaddr", a_rdaddr, m_bank ? pa : ca);
         if (e_brd) chk("b_rdaddr", b_rdaddr, m_bank ? ca : pa);
         chk("a_wren", a_wren, wr && m_bank);
         chk("b_wren", b_wren, wr && !m_bank);
         if (wr) begin
            chk("wraddr", wraddr, 9'(c - 3));
            chk("wrdata", wrdata, exp_nx[c-3]);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset(string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_cvalid"}, center_valid, 0);
      chk({tag, "_bank_sel"}, bank_sel, 0);
      chk({tag, "_center"}, center_out, 0);
      chk({tag, "_rden"}, {a_rden, b_rden}, 0);
      chk({tag, "_wren"}, {a_wren, b_wren}, 0);
      chk({tag, "_addr"}, {a_rdaddr, b_rdaddr, wraddr}, 0);
      chk({tag, "_wrdata"}, wrdata, 0);
   endtask

   task automatic do_reset();
      start = 1'b0;
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic load_mem();
      load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   task automatic zero_init();
      for (int i = 0; i < 512; i++) begin
         a_init[i] = '0;
         b_init[i] = '0;
      end
   endtask

   task automatic wait_done(output int k);
      k = 0;
      while (!done && k < R + 10) begin
         tick();
         k++;
      end
      chk("done_seen", done, 1);
   endtask

   task automatic run_step(output int k);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(k);
   endtask

   initial begin
      int k, a0, b0, d0;
      #3 reset = 1'b1;
      #1 check_reset("por");
      zero_init();
      tick();
      load_mem();
      do_reset();

      // zero column
      rho = 18'h02000;
      eta_term = '0;
      a0 = a_wr_cnt;
      b0 = b_wr_cnt;
      run_step(k);
      chk("zero_latency", k, R + 2);
      tick();
      chk("zero_bank_sel", bank_sel, 1);
      chk("zero_b_writes", b_wr_cnt - b0, R);
      chk("zero_a_writes", a_wr_cnt - a0, 0);

      // impulse
      do_reset();
      zero_init();
      a_init[1] = 18'h08000;
      load_mem();
      run_step(k);
      tick();
      chk_near("imp_b0", b_mem[0], 18'h00800);
      chk_near("imp_b1", b_mem[1], 18'h0E000);
      chk_near("imp_b2", b_mem[2], 18'h00800);
      chk("imp_b3", b_mem[3], 0);
      chk_near("imp_model1", exp_nx[1], 18'h0E000);
      chk("imp_a1_kept", a_mem[1], 18'h08000);

      // ping-pong
      a0 = a_wr_cnt;
      b0 = b_wr_cnt;
      run_step(k);
      tick();
      chk("pp_bank_sel", bank_sel, 0);
      chk("pp_a_writes", a_wr_cnt - a0, R);
      chk("pp_b_writes", b_wr_cnt - b0, 0);

      // rim and center
      do_reset();
      zero_init();
      a_init[R-1] = 18'h04000;
      load_mem();
      run_step(k);
      chk_near("rim_center", center_out, 18'h07000);
      chk("rim_center_eq_wr", center_out, b_mem[R-1]);
      chk_near("rim_row4", b_mem[R-2], 18'h00400);
      tick();

      // start while busy is ignored
      do_reset();
      d0 = n_done;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (R + 8) tick();
      chk("one_done", n_done - d0, 1);

      // reset mid-step at cycle 3
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      #1 reset = 1'b1;
      #1 check_reset("mid");
      a0 = a_wr_cnt;
      b0 = b_wr_cnt;
      repeat (2) tick();
      reset = 1'b0;
      repeat (R + 6) tick();
      chk("mid_no_writes", (a_wr_cnt - a0) + (b_wr_cnt - b0), 0);
      chk("mid_idle", busy, 0);

      // randomized steps, pulsed and held start
      do_reset();
      for (int i = 0; i < 512; i++) begin
         a_init[i] = (i < R) ? 18'($urandom) : '0;
         b_init[i] = (i < R) ? 18'($urandom) : '0;
      end
      load_mem();
      for (int seg = 0; seg < 16; seg++) begin
         int mode;
         mode = $urandom_range(0, 2);
         for (int t = 0; t < 40; t++) begin
            if (!m_act && $urandom_range(0, 1) == 1) begin
               rho = ($urandom_range(0, 3) == 0) ? 18'($urandom)
                                               : 18'($urandom_range(0, 18'h4000));
               eta_term = ($urandom_range(0, 3) == 0) ? 18'($urandom)
                                                    : 18'($urandom_range(0, 18'h800));
            end
            case (mode)
               0: start = 1'b1;
               1: start = ($urandom_range(0, 7) == 0);
               default: start = $urandom_range(0, 1) == 1;
            endcase
            tick();
         end
      end
      start = 1'b0;
      repeat (R + 8) tick();

      chk("no_oob_read", bad_rd, 0);
      chk("no_collision", coll, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/column_sweep_ctrl.md
# column_sweep_ctrl

Sequencer for one drum-mesh column. It sweeps rows 0..ROWS-1 of the column held in two ping-pong M10K banks and presents each node's center/up/down/previous values to an internal `column_node` update. It writes each `u_next` back into the bank that held `u_prev`, then swaps bank roles for the next time step. It sits between the per-column M10K pair and the top-level step scheduler, and exports the center-row sample for audio.

## Interface

**Parameters**
- `ROWS`, default 30: nodes per column, 3..512.
- `CENTER_ROW`, default 15: row whose `u_next` is exported as `center_out`.

**Ports**
- `clk`, in, 1: sole clock.
- `reset`, in, 1: asynchronous, active-high.
- `start`, in, 1: request one time step; sampled only in IDLE.
- `rho`, in, 18: signed 1.17 coupling coefficient; must be stable while `busy`.
- `eta_term`, in, 18: signed 1.17 damping term; must be stable while `busy`.
- `busy`, out, 1: high from the cycle after start is accepted until `done`.
- `done`, out, 1: one-cycle pulse when the step completes.
- `center_out`, out, 18: signed `u_next` of `CENTER_ROW` from the last completed step.
- `center_valid`, out, 1: one-cycle pulse, coincident with `done`.
- `bank_sel`, out, 1: 0 means bank A holds `u_n` and bank B holds `u_prev`; 1 means the reverse.
- `a_rdaddr`, `b_rdaddr`, out, 9: per-bank read addresses.
- `a_rden`, `b_rden`, out, 1: per-bank read enables.
- `a_q`, `b_q`, in, 18: bank read data, valid 2 cycles after the address and enable are presented.
- `wraddr`, out, 9: write address, shared by both banks.
- `wrdata`, out, 18: write data, shared by both banks.
- `a_wren`, `b_wren`, out, 1: per-bank write enables; never both high.

## Operation

**States**
- IDLE: `start` moves to RUN, cycle 0.
- RUN: issues reads for k = 0..ROWS-1.
- DRAIN: covers the 2-cycle read latency plus the final row.
- DONE: 1 cycle, asserts `done` and `center_valid`, toggles `bank_sel`, then returns to IDLE.

**Bank roles**
- cur bank = `bank_sel` ? B : A.
- prev bank = the other bank.

**Reads**
- At cycle k (0 ≤ k ≤ ROWS-1): cur bank reads row k.
- At cycle k (1 ≤ k ≤ ROWS): prev bank reads row k-1.
- Read enables are low on all other cycles.

**Window**
- A 3-deep shift register holds cur rows i-1, i, i+1.
- Out-of-range rows read as 0 (fixed rim):
  - row 0 sees `down` = 0;
  - row ROWS-1 sees `up` = 0, which is injected with no memory read.

**Compute**
- Row i is evaluated combinationally by `column_node` with `u_n` = cur[i], `u_n_prev` = prev[i], `u_n_up` = cur[i+1], `u_n_down` = cur[i-1].
- `g_tension` is tied to 0.

**Write**
- On the cycle row i is evaluated: `wraddr` = i, `wrdata` = `u_next`, and the prev-bank write enable is high.
- The cur bank is never written.

**Center capture**
- When i = `CENTER_ROW`, `u_next` is captured into a holding register.
- `center_out` updates from that register at DONE.

**Arithmetic**
- All values are 18-bit signed 1.17.
- Products are `signed_mult` truncation.
- There is no saturation; overflow wraps.

**Start handling**
- `start` is ignored while `busy`.
- `start` held high continuously launches back-to-back steps, with IDLE for 1 cycle between them.

## Timing

- Start accepted at cycle 0 (IDLE with `start` high).
- Row i is written at cycle i+3.
- The last write occurs at cycle ROWS+2.
- `done` and `center_valid` pulse at cycle ROWS+3.
- `bank_sel` toggles at the clock edge ending cycle ROWS+3.
- `busy` is high for cycles 1..ROWS+3.
- Reset values: state IDLE, `bank_sel` 0, `busy` 0, `done` 0, `center_valid` 0, `center_out` 0, all enables 0, all addresses 0, `wrdata` 0.
- Reset mid-step:
  - all write enables drop asynchronously;
  - `bank_sel` returns to 0 regardless of parity;
  - a partially written prev bank is not repaired, so the scheduler must reinitialize the memories.
- Write/read collision: never occurs to the same bank, because writes go to the prev bank at row i while the prev bank reads row ≥ i+1.

## Structure

- Shared package holds:
  - data width 18 and address width 9;
  - the state encoding (IDLE/RUN/DRAIN/DONE);
  - the 1.17 constant `ONE_MINUS_LSB` = 18'h1ffff.
- Exactly one sub-module, `column_node`, instantiated once.
- The M10K banks stay outside this block, in the column wrapper.

## Test plan

- **Reset values:** assert `reset` mid-cycle with no clock edge → all outputs at their reset values immediately.
- **Zero column:** ROWS=4, both banks zero, `rho`=0x02000, `eta_term`=0, pulse `start` → writes rows 0..3 with data 0 at cycles 3..6 to bank B only; `done` at cycle 7; `bank_sel` becomes 1.
- **Impulse:** ROWS=4, A[1]=0x08000, all else 0, `rho`=0x02000, `eta_term`=0 → B[0]≈0x00800, B[1]≈0x0E000, B[2]≈0x00800, B[3]=0, each within 2 LSB.
- **Ping-pong:** run a second step after the impulse → reads cur from B and prev from A; writes go to A; `bank_sel` returns to 0 after `done`.
- **Rim and center:** ROWS=5, `CENTER_ROW`=4, A[4]=0x04000 → the row-4 computation uses `up`=0, no bank read at address 5 ever occurs, and `center_out` equals the row-4 write data at `done`.
- **Control edges:** pulse `start` at cycle 2 while `busy` → ignored, only one `done`; assert `reset` at cycle 3 → no write enable after reset, state IDLE, `bank_sel`=0.
